// File: rtl/dot_pair_serializer_pkg.sv
// Shared sizing constants and state encoding for the dot-product pair serializer.
package dot_pair_serializer_pkg;

  localparam int N  = 10;  // elements per vector
  localparam int W  = 4;   // element width, unsigned
  localparam int SW = 32;  // running-sum width
  localparam int IW = 4;   // index width, 2**IW >= N

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/dot_pair_serializer.sv
// Captures an x/h vector pair in parallel and streams one (x[i],h[i]) element per
// valid/ready handshake, keeping a running dot-product sum with a done pulse.
module dot_pair_serializer
  import dot_pair_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [N*W-1:0]    x_vec,
  input  logic [N*W-1:0]    h_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_x,
  output logic [W-1:0]      out_h,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              done,
  output logic [SW-1:0]     dot_sum
);

  state_t                state_q, state_d;
  logic [N-1:0][W-1:0]   x_q, h_q;
  logic [IW-1:0]         idx_q;
  logic [SW-1:0]         sum_q;
  logic                  done_q;

  logic                  load_fire;
  logic                  xfer;
  logic                  idx_last;
  logic [2*W-1:0]        product;

  assign load_fire = (state_q == IDLE) && load_valid;
  assign xfer      = (state_q == SEND) && out_ready;
  assign idx_last  = (idx_q == IW'(N - 1));
  assign product   = (2*W)'(x_q[idx_q]) * (2*W)'(h_q[idx_q]);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_valid)          state_d = SEND;
      SEND: if (xfer && idx_last)    state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the capture regs are reset too, because out_x/out_h decode from them and must read 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      h_q    <= '0;
      idx_q  <= '0;
      sum_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && idx_last;
      if (load_fire) begin
        x_q   <= x_vec;
        h_q   <= h_vec;
        idx_q <= '0;
        sum_q <= '0;
      end else if (xfer) begin
        sum_q <= sum_q + SW'(product);
        // Wrap back to 0 after the last element so idx never exceeds N-1.
        idx_q <= idx_last ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign load_ready = (state_q == IDLE);
  assign out_valid  = (state_q == SEND);
  assign out_x      = x_q[idx_q];
  assign out_h      = h_q[idx_q];
  assign out_idx    = idx_q;
  assign out_last   = out_valid && idx_last;
  assign done       = done_q;
  assign dot_sum    = sum_q;

endmodule

// File: tb/tb_dot_pair_serializer.sv
// Self-checking bench for dot_pair_serializer: directed vectors plus randomized
// vectors and out_ready patterns, compared against an element-list reference model.
module tb_dot_pair_serializer;
  import dot_pair_serializer_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [N*W-1:0]    x_vec = '0;
  logic [N*W-1:0]    h_vec = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_x;
  logic [W-1:0]      out_h;
  logic [IW-1:0]     out_idx;
  logic              out_last;
  logic              done;
  logic [SW-1:0]     dot_sum;

  dot_pair_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .x_vec      (x_vec),
    .h_vec      (h_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_h      (out_h),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .done       (done),
    .dot_sum    (dot_sum)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          xs[N];
  int          hs[N];
  logic [31:0] model_sum;
  int          lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic randomize_vectors();
    for (int i = 0; i < N; i++) begin
      xs[i] = int'($urandom_range(0, 15));
      hs[i] = int'($urandom_range(0, 15));
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge presenting element 0.
  task automatic do_load();
    check("load_ready_before_load", load_ready, 1);
    for (int i = 0; i < N; i++) begin
      x_vec[i*W +: W] = W'(xs[i]);
      h_vec[i*W +: W] = W'(hs[i]);
    end
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    model_sum  = 0;
  endtask

  // mode 0: out_ready high, 1: toggle starting high, 2: random. Ends at the done negedge.
  task automatic run_elements(input int mode, input bit pulse_junk, output int cycles);
    int  k;
    int  cyc;
    bit  rdy;
    k   = 0;
    cyc = 1;
    while (k < N && cyc < 4*N + 20) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (pulse_junk) begin
        load_valid = (cyc == 3);
        x_vec = ~x_vec;
        h_vec = h_vec ^ {N{4'b0101}};
      end
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, k);
      check("out_x", out_x, xs[k]);
      check("out_h", out_h, hs[k]);
      check("out_last", out_last, (k == N - 1));
      check("done_during_send", done, 0);
      check("load_ready_during_send", load_ready, 0);
      check("running_sum", dot_sum, model_sum);
      if (rdy) begin
        model_sum = model_sum + 32'(xs[k] * hs[k]);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready  = 1'b0;
    load_valid = 1'b0;
    check("stream_complete_in_budget", k, N);
    check("done_pulse", done, 1);
    check("out_valid_after_last", out_valid, 0);
    check("load_ready_at_done", load_ready, 1);
    check("dot_sum_at_done", dot_sum, model_sum);
    cycles = cyc;
  endtask

  initial begin
    // 1. reset held for 10 cycles
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_load_ready", load_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_dot_sum", dot_sum, 0);
    check("reset_out_idx", out_idx, 0);
    check("reset_out_x", out_x, 0);
    check("reset_out_last", out_last, 0);

    // 2. directed vector, out_ready held high
    xs = '{1, 2, 2, 3, 4, 1, 3, 2, 1, 2};
    hs = '{10, 1, 4, 2, 3, 1, 0, 1, 2, 1};
    do_load();
    run_elements(0, 1'b0, lat);
    check("t2_dot_sum", dot_sum, 45);
    check("t2_latency", lat, N + 1);
    @(negedge clk);
    check("t2_done_once", done, 0);
    check("t2_sum_held", dot_sum, 45);

    // 3. out_ready toggling every cycle
    xs = '{1, 10, 2, 3, 4, 8, 3, 2, 9, 12};
    do_load();
    run_elements(1, 1'b0, lat);
    check("t3_dot_sum", dot_sum, 86);
    check("t3_latency", lat, 2 * N);
    @(negedge clk);
    check("t3_done_once", done, 0);

    // 4. max values, then back-to-back load in the done cycle
    for (int i = 0; i < N; i++) begin
      xs[i] = 15;
      hs[i] = 15;
    end
    do_load();
    run_elements(0, 1'b0, lat);
    check("t4_dot_sum_max", dot_sum, 2250);
    randomize_vectors();
    do_load();
    check("t4_b2b_sum_cleared", dot_sum, 0);
    check("t4_b2b_done_low", done, 0);
    run_elements(2, 1'b0, lat);
    @(negedge clk);
    check("t4_b2b_done_once", done, 0);

    // 5. reset after idx 4 transferred
    randomize_vectors();
    do_load();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_idx != 5; c++) @(negedge clk);
    check("t5_reached_idx5", out_idx, 5);
    reset = 1'b1;
    #1;
    check("t5_async_out_valid", out_valid, 0);
    check("t5_async_dot_sum", dot_sum, 0);
    check("t5_async_out_idx", out_idx, 0);
    check("t5_async_out_x", out_x, 0);
    check("t5_async_done", done, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_no_done_after_abort", done, 0);
      check("t5_idle_after_abort", out_valid, 0);
    end
    randomize_vectors();
    do_load();
    run_elements(2, 1'b0, lat);
    @(negedge clk);

    // 6. load_valid pulsed with other vectors during SEND is ignored
    randomize_vectors();
    do_load();
    run_elements(0, 1'b1, lat);
    @(negedge clk);
    check("t6_no_reload", out_valid, 0);

    // randomized loads with random backpressure
    for (int r = 0; r < 6; r++) begin
      randomize_vectors();
      do_load();
      run_elements(2, 1'b0, lat);
      @(negedge clk);
      check("rand_done_once", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
